// File: rtl/mixcol_arbiter_pkg.sv
// Shared definitions for the mixcolum arbiter: FSM encoding, mixcolum timing
// and the round-robin reset pointer.
package mixcol_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  // mixcolum needs one cycle per column after start
  localparam int unsigned MC_LATENCY = 4;

  // requester 0 wins the first tie after reset
  localparam logic LAST_GRANT_RST = 1'b1;

endpackage

// File: rtl/mixcol_arbiter_rr_arb2.sv
// Two-way round-robin grant: combinational one-hot grant plus the
// last-grant pointer, updated whenever a grant is issued.
module rr_arb2
  import mixcol_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] valid,
  input  logic       enable,
  output logic [1:0] grant_onehot
);

  logic       last_grant_r;
  logic [1:0] pick_s;

  // pick a single winner; ties go to the side not served last
  always_comb begin
    pick_s = 2'b00;
    case (valid)
      2'b01:   pick_s = 2'b01;
      2'b10:   pick_s = 2'b10;
      2'b11:   pick_s = last_grant_r ? 2'b01 : 2'b10;
      default: pick_s = 2'b00;
    endcase
    if (enable) begin
      grant_onehot = pick_s;
    end else begin
      grant_onehot = 2'b00;
    end
  end

  // remember who was granted last
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant_r <= LAST_GRANT_RST;
    end else if (grant_onehot != 2'b00) begin
      last_grant_r <= grant_onehot[1];
    end else begin
      last_grant_r <= last_grant_r;
    end
  end

endmodule

// File: rtl/mixcol_arbiter.sv
// Shares one mixcolum unit between two requesters: round-robin accept,
// start handshake, result return to the owner, and a completion watchdog.
module mixcol_arbiter
  import mixcol_arbiter_pkg::*;
#(
  parameter int unsigned WAIT_LIMIT = 15
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req0_valid_i,
  input  logic         req0_decrypt_i,
  input  logic [127:0] req0_data_i,
  output logic         req0_ready_o,
  input  logic         req1_valid_i,
  input  logic         req1_decrypt_i,
  input  logic [127:0] req1_data_i,
  output logic         req1_ready_o,
  output logic [1:0]   rsp_valid_o,
  output logic [127:0] rsp_data_o,
  output logic         err_o,
  output logic         busy_o,
  output logic         mc_start_o,
  output logic         mc_decrypt_o,
  output logic [127:0] mc_data_o,
  input  logic         mc_ready_i,
  input  logic [127:0] mc_data_i
);

  // a shorter limit would fire before mixcolum can possibly finish
  if (WAIT_LIMIT < MC_LATENCY + 1 || WAIT_LIMIT > 15) begin : g_bad_limit
    $error("mixcol_arbiter: WAIT_LIMIT out of range 5..15");
  end

  localparam logic [3:0] WCNT_LAST = 4'(WAIT_LIMIT - 1);

  state_t       state_r, state_s;
  logic [1:0]   grant_s;
  logic         accept_s;
  logic         owner_r;
  logic         op_dec_r;
  logic [127:0] op_data_r;
  logic [3:0]   wcnt_r;
  logic [1:0]   rsp_valid_r;
  logic [127:0] rsp_data_r;
  logic         err_r;

  rr_arb2 u_rr_arb2 (
    .clk          (clk),
    .reset        (reset),
    .valid        ({req1_valid_i, req0_valid_i}),
    .enable       (state_r == ST_IDLE),
    .grant_onehot (grant_s)
  );

  assign accept_s     = (grant_s != 2'b00);
  assign req0_ready_o = grant_s[0];
  assign req1_ready_o = grant_s[1];

  assign busy_o       = (state_r != ST_IDLE);
  assign mc_start_o   = (state_r == ST_START);
  assign mc_data_o    = op_data_r;
  assign mc_decrypt_o = op_dec_r;
  assign rsp_valid_o  = rsp_valid_r;
  assign rsp_data_o   = rsp_data_r;
  assign err_o        = err_r;

  // next-state decode
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_s = ST_START;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_START: state_s = ST_WAIT;
      ST_WAIT: begin
        if (mc_ready_i || (wcnt_r == WCNT_LAST)) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_WAIT;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // state, captured operand, watchdog and registered responses
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      owner_r     <= 1'b0;
      op_dec_r    <= 1'b0;
      op_data_r   <= 128'd0;
      wcnt_r      <= 4'd0;
      rsp_valid_r <= 2'b00;
      rsp_data_r  <= 128'd0;
      err_r       <= 1'b0;
    end else begin
      state_r     <= state_s;
      rsp_valid_r <= 2'b00;
      err_r       <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            owner_r   <= grant_s[1];
            op_dec_r  <= grant_s[1] ? req1_decrypt_i : req0_decrypt_i;
            op_data_r <= grant_s[1] ? req1_data_i : req0_data_i;
          end else begin
            owner_r   <= owner_r;
          end
        end
        ST_START: wcnt_r <= 4'd0;
        ST_WAIT: begin
          wcnt_r <= wcnt_r + 4'd1;
          if (mc_ready_i) begin
            rsp_data_r  <= mc_data_i;
            rsp_valid_r <= owner_r ? 2'b10 : 2'b01;
          end else if (wcnt_r == WCNT_LAST) begin
            err_r <= 1'b1;
          end else begin
            err_r <= 1'b0;
          end
        end
        default: wcnt_r <= 4'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_mixcol_arbiter.sv
// Directed bench for mixcol_arbiter with a behavioural column-serial
// mixcolum stand-in behind the mc_* ports.
module tb_mixcol_arbiter;

  localparam logic [127:0] VEC_A = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] VEC_B = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] VEC_C = 128'hd4d4d4d5_2d26314c_c6c6c6c6_01010101;
  localparam logic [127:0] VEC_D = 128'hd5d5d7d6_4d7ebdf8_c6c6c6c6_01010101;

  logic         clk = 1'b0;
  logic         reset;
  logic         req0_valid, req0_decrypt, req0_ready;
  logic [127:0] req0_data;
  logic         req1_valid, req1_decrypt, req1_ready;
  logic [127:0] req1_data;
  logic [1:0]   rsp_valid;
  logic [127:0] rsp_data;
  logic         err, busy;
  logic         mc_start, mc_decrypt, mc_ready;
  logic [127:0] mc_data_o, mc_res;
  logic [2:0]   mc_cnt;
  logic         mc_stall;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  mixcol_arbiter #(.WAIT_LIMIT(15)) dut (
    .clk            (clk),
    .reset          (reset),
    .req0_valid_i   (req0_valid),
    .req0_decrypt_i (req0_decrypt),
    .req0_data_i    (req0_data),
    .req0_ready_o   (req0_ready),
    .req1_valid_i   (req1_valid),
    .req1_decrypt_i (req1_decrypt),
    .req1_data_i    (req1_data),
    .req1_ready_o   (req1_ready),
    .rsp_valid_o    (rsp_valid),
    .rsp_data_o     (rsp_data),
    .err_o          (err),
    .busy_o         (busy),
    .mc_start_o     (mc_start),
    .mc_decrypt_o   (mc_decrypt),
    .mc_data_o      (mc_data_o),
    .mc_ready_i     (mc_ready),
    .mc_data_i      (mc_res)
  );

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] b, input logic [3:0] k);
    logic [7:0] p, r;
    p = b;
    r = 8'h00;
    for (int i = 0; i < 4; i++) begin
      if (k[i]) r ^= p;
      p = xt(p);
    end
    return r;
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] w, input logic dec);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = w;
    if (!dec)
      return {gm(a0,4'd2)^gm(a1,4'd3)^a2^a3, a0^gm(a1,4'd2)^gm(a2,4'd3)^a3,
              a0^a1^gm(a2,4'd2)^gm(a3,4'd3), gm(a0,4'd3)^a1^a2^gm(a3,4'd2)};
    else
      return {gm(a0,4'd14)^gm(a1,4'd11)^gm(a2,4'd13)^gm(a3,4'd9),
              gm(a0,4'd9)^gm(a1,4'd14)^gm(a2,4'd11)^gm(a3,4'd13),
              gm(a0,4'd13)^gm(a1,4'd9)^gm(a2,4'd14)^gm(a3,4'd11),
              gm(a0,4'd11)^gm(a1,4'd13)^gm(a2,4'd9)^gm(a3,4'd14)};
  endfunction

  // mixcolum stand-in: one column per cycle from the live operand, ready after the 4th
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mc_cnt   <= 3'd0;
      mc_ready <= 1'b0;
      mc_res   <= 128'd0;
    end else begin
      mc_ready <= 1'b0;
      case (mc_cnt)
        3'd0: if (mc_start) mc_cnt <= 3'd1;
        3'd1: begin mc_res[127:96] <= mix_col(mc_data_o[127:96], mc_decrypt); mc_cnt <= 3'd2; end
        3'd2: begin mc_res[95:64]  <= mix_col(mc_data_o[95:64],  mc_decrypt); mc_cnt <= 3'd3; end
        3'd3: begin mc_res[63:32]  <= mix_col(mc_data_o[63:32],  mc_decrypt); mc_cnt <= 3'd4; end
        default: begin
          mc_res[31:0] <= mix_col(mc_data_o[31:0], mc_decrypt);
          mc_cnt       <= 3'd0;
          mc_ready     <= !mc_stall;
        end
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic wait_rsp(output int lat);
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (rsp_valid != 2'b00) begin
        lat = i;
        break;
      end
    end
  endtask

  initial begin
    int lat, err_n, err_at, rsp_n;
    reset = 1'b0; mc_stall = 1'b0;
    req0_valid = 1'b0; req0_decrypt = 1'b0; req0_data = 128'd0;
    req1_valid = 1'b0; req1_decrypt = 1'b0; req1_data = 128'd0;
    tick(); tick();
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_start", 128'(mc_start), 128'd0);
    check("rst_mc_data", mc_data_o, 128'd0);
    check("rst_rsp_valid", 128'(rsp_valid), 128'd0);
    check("rst_rsp_data", rsp_data, 128'd0);
    check("rst_err", 128'(err), 128'd0);
    reset = 1'b1;
    tick();

    // single encrypt from requester 0
    req0_valid = 1'b1; req0_decrypt = 1'b0; req0_data = VEC_A;
    #1;
    check("enc_ready0", 128'({req1_ready, req0_ready}), 128'd1);
    tick();
    req0_valid = 1'b0;
    check("enc_start", 128'({busy, mc_start, req0_ready}), 128'd6);
    check("enc_mc_data", mc_data_o, VEC_A);
    wait_rsp(lat);
    check("enc_latency", 128'(lat), 128'd6);
    check("enc_rsp_valid", 128'(rsp_valid), 128'd1);
    check("enc_rsp_data", rsp_data, VEC_B);
    check("enc_idle", 128'({busy, err}), 128'd0);
    tick();
    check("enc_pulse", 128'(rsp_valid), 128'd0);
    check("enc_hold", rsp_data, VEC_B);

    // single decrypt from requester 1
    req1_valid = 1'b1; req1_decrypt = 1'b1; req1_data = VEC_B;
    #1;
    check("dec_ready1", 128'({req1_ready, req0_ready}), 128'd2);
    tick();
    req1_valid = 1'b0;
    check("dec_mc_dec", 128'(mc_decrypt), 128'd1);
    wait_rsp(lat);
    check("dec_latency", 128'(lat), 128'd6);
    check("dec_rsp_valid", 128'(rsp_valid), 128'd2);
    check("dec_rsp_data", rsp_data, VEC_A);

    // contention straight after reset
    reset = 1'b0; tick(); reset = 1'b1;
    req0_valid = 1'b1; req0_decrypt = 1'b0; req0_data = VEC_A;
    req1_valid = 1'b1; req1_decrypt = 1'b1; req1_data = VEC_B;
    #1;
    check("tie1_ready", 128'({req1_ready, req0_ready}), 128'd1);
    tick();
    req0_data = VEC_C;
    #1;
    check("tie1_busy_ready", 128'({req1_ready, req0_ready}), 128'd0);
    wait_rsp(lat);
    check("tie1_latency", 128'(lat), 128'd6);
    check("tie1_rsp", {126'd0, rsp_valid}, 128'd1);
    check("tie1_data", rsp_data, VEC_B);
    check("tie2_ready", 128'({req1_ready, req0_ready}), 128'd2);
    tick();
    req1_valid = 1'b0;
    wait_rsp(lat);
    check("tie2_latency", 128'(lat), 128'd6);
    check("tie2_rsp", 128'(rsp_valid), 128'd2);
    check("tie2_data", rsp_data, VEC_A);
    check("tie3_ready", 128'({req1_ready, req0_ready}), 128'd1);
    tick();
    req0_valid = 1'b0;
    wait_rsp(lat);
    check("tie3_latency", 128'(lat), 128'd6);
    check("tie3_rsp", 128'(rsp_valid), 128'd1);
    check("tie3_data", rsp_data, VEC_D);

    // operand must stay captured while the requester moves on
    tick();
    req0_valid = 1'b1; req0_decrypt = 1'b0; req0_data = VEC_C;
    tick();
    req0_valid = 1'b0; req0_decrypt = 1'b1; req0_data = {4{32'hffff0000}};
    check("stab_mc_data0", mc_data_o, VEC_C);
    for (int i = 1; i <= 4; i++) begin
      tick();
      check("stab_mc_data", mc_data_o, VEC_C);
      check("stab_mc_dec", 128'(mc_decrypt), 128'd0);
    end
    wait_rsp(lat);
    check("stab_latency", 128'(lat), 128'd2);
    check("stab_data", rsp_data, VEC_D);

    // watchdog: completion suppressed
    mc_stall = 1'b1;
    req1_valid = 1'b1; req1_decrypt = 1'b0; req1_data = VEC_A;
    tick();
    req1_valid = 1'b0;
    err_n = 0; err_at = 0; rsp_n = 0;
    for (int i = 1; i <= 25; i++) begin
      tick();
      if (err) begin
        err_n++;
        if (err_at == 0) err_at = i;
        check("wd_busy_drop", 128'(busy), 128'd0);
      end
      if (rsp_valid != 2'b00) rsp_n++;
    end
    check("wd_err_at", 128'(err_at), 128'd16);
    check("wd_err_once", 128'(err_n), 128'd1);
    check("wd_no_rsp", 128'(rsp_n), 128'd0);
    mc_stall = 1'b0;
    req0_valid = 1'b1; req0_decrypt = 1'b0; req0_data = VEC_A;
    tick();
    req0_valid = 1'b0;
    wait_rsp(lat);
    check("wd_recover_lat", 128'(lat), 128'd6);
    check("wd_recover_data", rsp_data, VEC_B);

    // reset while START is about to hand over to WAIT
    tick();
    req0_valid = 1'b1; req0_decrypt = 1'b0; req0_data = VEC_C;
    tick();
    req0_valid = 1'b0;
    check("mid_start", 128'(mc_start), 128'd1);
    reset = 1'b0;
    #1;
    check("mid_outs", 128'({busy, mc_start, err, rsp_valid}), 128'd0);
    check("mid_mc_data", mc_data_o, 128'd0);
    check("mid_rsp_data", rsp_data, 128'd0);
    tick();
    reset = 1'b1;
    rsp_n = 0; err_n = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (rsp_valid != 2'b00) rsp_n++;
      if (err) err_n++;
    end
    check("mid_no_rsp", 128'(rsp_n), 128'd0);
    check("mid_no_err", 128'(err_n), 128'd0);
    req1_valid = 1'b1; req1_decrypt = 1'b1; req1_data = VEC_B;
    tick();
    req1_valid = 1'b0;
    wait_rsp(lat);
    check("post_rst_lat", 128'(lat), 128'd6);
    check("post_rst_rsp", 128'(rsp_valid), 128'd2);
    check("post_rst_data", rsp_data, VEC_A);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
